// File: rtl/bomb_pkg.sv
// Shared game-state encoding and helpers used by the controller, the countdown timer and the puzzles.
package bomb_pkg;

  typedef logic [7:0] game_state_t;

  localparam game_state_t GS_IDLE     = 8'h00;
  localparam game_state_t GS_ARMING   = 8'h01;
  localparam game_state_t GS_RUNNING  = 8'h10;
  localparam game_state_t GS_DEFUSED  = 8'h20;
  localparam game_state_t GS_EXPLODED = 8'h30;

  localparam int MAX_MODULES = 8;

  // Counts set bits of an up-to-eight-wide strike vector; callers zero-extend narrower vectors.
  function automatic logic [3:0] popcount(input logic [MAX_MODULES-1:0] vec);
    logic [3:0] total;
    total = '0;
    for (int i = 0; i < MAX_MODULES; i++) begin
      total = total + {3'b000, vec[i]};
    end
    return total;
  endfunction

endpackage

// File: rtl/bomb_game_controller_if.sv
// Game bus between the sequencer and its environment: button, puzzle events and timer digits in, status out.
interface bomb_game_controller_if #(
  parameter int NUM_MODULES = 4
);

  logic                   start;
  logic [NUM_MODULES-1:0] solved;
  logic [NUM_MODULES-1:0] strike;
  logic [3:0]             value_three;
  logic [3:0]             value_two;
  logic [3:0]             value_one;

  logic [7:0]             game_state;
  logic [NUM_MODULES-1:0] solved_mask;
  logic [NUM_MODULES-1:0] module_enable;
  logic [1:0]             strike_count;
  logic                   state_change;

  modport master (
    output start, solved, strike, value_three, value_two, value_one,
    input  game_state, solved_mask, module_enable, strike_count, state_change
  );

  modport slave (
    input  start, solved, strike, value_three, value_two, value_one,
    output game_state, solved_mask, module_enable, strike_count, state_change
  );

endinterface

// File: rtl/bomb_game_controller_strike_counter.sv
// Saturating strike accumulator; count_d exposes the next value so the sequencer can decide on it this cycle.
module strike_counter
  import bomb_pkg::*;
#(
  parameter int NUM_MODULES = 4,
  parameter int MAX_STRIKES = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   enable,
  input  logic [NUM_MODULES-1:0] strike_vec,
  output logic [1:0]             count_q,
  output logic [1:0]             count_d
);

  localparam logic [4:0] LIMIT = 5'(MAX_STRIKES);

  logic [MAX_MODULES-1:0] strike_wide;
  logic [4:0]             sum;

  always_comb begin
    strike_wide = '0;
    strike_wide[NUM_MODULES-1:0] = strike_vec;
    sum = {3'b000, count_q} + {1'b0, popcount(strike_wide)};
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = (sum >= LIMIT) ? LIMIT[1:0] : sum[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bomb_game_controller.sv
// Top-level game sequencer: IDLE -> ARMING -> RUNNING -> DEFUSED/EXPLODED, holding the result until restart.
module bomb_game_controller
  import bomb_pkg::*;
#(
  parameter int NUM_MODULES = 4,
  parameter int MAX_STRIKES = 3,
  parameter int ARM_CYCLES  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  bomb_game_controller_if.slave bus
);

  localparam int                ARM_W     = $clog2(ARM_CYCLES);
  localparam logic [ARM_W-1:0]  ARM_LAST  = ARM_W'(ARM_CYCLES - 1);
  localparam logic [1:0]        MAX_COUNT = 2'(MAX_STRIKES);
  localparam logic [1:0]        HOLDOFF   = 2'd2;

  game_state_t            state_q, state_d;
  logic [ARM_W-1:0]       arm_cnt_q, arm_cnt_d;
  logic [1:0]             run_cnt_q, run_cnt_d;
  logic [NUM_MODULES-1:0] solved_mask_q, solved_mask_d;
  logic [NUM_MODULES-1:0] module_enable_q, module_enable_d;
  logic                   state_change_q, state_change_d;
  logic [1:0]             strike_count_q, strike_count_d;

  logic                   strike_clear;
  logic                   strike_enable;
  logic [NUM_MODULES-1:0] strike_eff;
  logic                   timer_zero;
  logic                   expiry_armed;
  logic                   all_solved;
  logic                   strike_limit;

  // A solve in the same cycle as a strike on that module wins, so strikes are masked by the next mask.
  assign strike_eff = bus.strike & ~(solved_mask_q | bus.solved);

  strike_counter #(
    .NUM_MODULES(NUM_MODULES),
    .MAX_STRIKES(MAX_STRIKES)
  ) u_strike_counter (
    .clk       (clk),
    .reset     (reset),
    .clear     (strike_clear),
    .enable    (strike_enable),
    .strike_vec(strike_eff),
    .count_q   (strike_count_q),
    .count_d   (strike_count_d)
  );

  always_comb begin
    solved_mask_d = solved_mask_q;
    arm_cnt_d     = arm_cnt_q;
    run_cnt_d     = run_cnt_q;
    strike_clear  = 1'b0;
    strike_enable = 1'b0;
    case (state_q)
      GS_IDLE: begin
        if (bus.start) begin
          solved_mask_d = '0;
          arm_cnt_d     = '0;
          strike_clear  = 1'b1;
        end
      end
      GS_ARMING: begin
        arm_cnt_d = arm_cnt_q + ARM_W'(1);
        run_cnt_d = '0;
      end
      GS_RUNNING: begin
        solved_mask_d = solved_mask_q | bus.solved;
        strike_enable = 1'b1;
        if (run_cnt_q != HOLDOFF) begin
          run_cnt_d = run_cnt_q + 2'd1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      solved_mask_q <= '0;
      arm_cnt_q     <= '0;
      run_cnt_q     <= '0;
    end else begin
      solved_mask_q <= solved_mask_d;
      arm_cnt_q     <= arm_cnt_d;
      run_cnt_q     <= run_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= GS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign timer_zero   = (bus.value_three == 4'd0) && (bus.value_two == 4'd0) && (bus.value_one == 4'd0);
  assign expiry_armed = (run_cnt_q == HOLDOFF);
  assign all_solved   = &solved_mask_d;
  assign strike_limit = (strike_count_d == MAX_COUNT);

  // The timer needs two RUNNING cycles to load, so a zero reading before then is stale.
  always_comb begin
    state_d = state_q;
    case (state_q)
      GS_IDLE: begin
        if (bus.start) state_d = GS_ARMING;
      end
      GS_ARMING: begin
        if (arm_cnt_q == ARM_LAST) state_d = GS_RUNNING;
      end
      GS_RUNNING: begin
        if (strike_limit) begin
          state_d = GS_EXPLODED;
        end else if (all_solved) begin
          state_d = GS_DEFUSED;
        end else if (timer_zero && expiry_armed) begin
          state_d = GS_EXPLODED;
        end
      end
      GS_DEFUSED, GS_EXPLODED: begin
        if (bus.start) state_d = GS_IDLE;
      end
      default: state_d = GS_IDLE;
    endcase
  end

  always_comb begin
    module_enable_d = '0;
    if (state_d == GS_RUNNING) begin
      module_enable_d = ~solved_mask_d;
    end
    state_change_d = (state_d != state_q);
  end

  // Reset out of any non-idle state is itself a transition and gets its pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      module_enable_q <= '0;
      state_change_q  <= (state_q != GS_IDLE);
    end else begin
      module_enable_q <= module_enable_d;
      state_change_q  <= state_change_d;
    end
  end

  assign bus.game_state    = state_q;
  assign bus.solved_mask   = solved_mask_q;
  assign bus.module_enable = module_enable_q;
  assign bus.strike_count  = strike_count_q;
  assign bus.state_change  = state_change_q;

endmodule

// File: tb/tb_bomb_game_controller.sv
// Directed bench for bomb_game_controller: a phase-level game model checked every cycle plus literal spot checks.
module tb_bomb_game_controller;

  localparam int NUM_MODULES = 4;
  localparam int MAX_STRIKES = 3;
  localparam int ARM_CYCLES  = 16;

  localparam int P_IDLE     = 0;
  localparam int P_ARMING   = 1;
  localparam int P_RUNNING  = 2;
  localparam int P_DEFUSED  = 3;
  localparam int P_EXPLODED = 4;

  logic clk = 1'b0;
  logic reset;
  bit   compare_on = 1'b0;

  int check_count = 0;
  int pass_count  = 0;

  int         m_phase = P_IDLE;
  int         m_prev_phase;
  int         m_arm_seen;
  int         m_run_seen;
  int         m_strikes = 0;
  logic [3:0] m_mask = 4'h0;
  logic       m_change = 1'b0;
  logic [3:0] m_enable;

  bomb_game_controller_if #(.NUM_MODULES(NUM_MODULES)) bus_if ();

  bomb_game_controller #(
    .NUM_MODULES(NUM_MODULES),
    .MAX_STRIKES(MAX_STRIKES),
    .ARM_CYCLES (ARM_CYCLES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  function automatic int phaseCode(input int p);
    case (p)
      P_ARMING:   return 32'h01;
      P_RUNNING:  return 32'h10;
      P_DEFUSED:  return 32'h20;
      P_EXPLODED: return 32'h30;
      default:    return 32'h00;
    endcase
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    check_count++;
    if (actual == expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Game rules at phase level: what each posedge does to the game, from the sampled inputs.
  always @(posedge clk) begin
    m_prev_phase = m_phase;
    if (reset) begin
      m_phase   = P_IDLE;
      m_mask    = 4'h0;
      m_strikes = 0;
    end else begin
      case (m_phase)
        P_IDLE: begin
          if (bus_if.start) begin
            m_phase    = P_ARMING;
            m_mask     = 4'h0;
            m_strikes  = 0;
            m_arm_seen = 0;
          end
        end
        P_ARMING: begin
          m_arm_seen++;
          if (m_arm_seen == ARM_CYCLES) begin
            m_phase    = P_RUNNING;
            m_run_seen = 0;
          end
        end
        P_RUNNING: begin
          m_mask    = m_mask | bus_if.solved;
          m_strikes = m_strikes + $countones(bus_if.strike & ~m_mask);
          if (m_strikes > MAX_STRIKES) m_strikes = MAX_STRIKES;
          if (m_strikes == MAX_STRIKES) begin
            m_phase = P_EXPLODED;
          end else if (m_mask == 4'hF) begin
            m_phase = P_DEFUSED;
          end else if (bus_if.value_three == 0 && bus_if.value_two == 0 &&
                       bus_if.value_one == 0 && m_run_seen >= 2) begin
            m_phase = P_EXPLODED;
          end
          m_run_seen++;
        end
        default: begin
          if (bus_if.start) m_phase = P_IDLE;
        end
      endcase
    end
    m_change = (m_phase != m_prev_phase);
    m_enable = (m_phase == P_RUNNING) ? ~m_mask : 4'h0;
  end

  always @(negedge clk) begin
    if (compare_on) begin
      checkOutput("model game_state", int'(bus_if.game_state), phaseCode(m_phase));
      checkOutput("model solved_mask", int'(bus_if.solved_mask), int'(m_mask));
      checkOutput("model module_enable", int'(bus_if.module_enable), int'(m_enable));
      checkOutput("model strike_count", int'(bus_if.strike_count), m_strikes);
      checkOutput("model state_change", int'(bus_if.state_change), int'(m_change));
    end
  end

  // Drives one cycle of inputs and returns at the following negedge with pulses cleared.
  task automatic applyStimulus(input logic st, input logic [3:0] sol, input logic [3:0] stk);
    bus_if.start  = st;
    bus_if.solved = sol;
    bus_if.strike = stk;
    @(negedge clk);
    bus_if.start  = 1'b0;
    bus_if.solved = 4'h0;
    bus_if.strike = 4'h0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic setDigits(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1);
    bus_if.value_three = d3;
    bus_if.value_two   = d2;
    bus_if.value_one   = d1;
  endtask

  task automatic startGame();
    applyStimulus(1'b1, 4'h0, 4'h0);
    idleCycles(ARM_CYCLES);
    checkOutput("game running", int'(bus_if.game_state), 32'h10);
  endtask

  initial begin
    reset = 1'b1;
    bus_if.start  = 1'b0;
    bus_if.solved = 4'h0;
    bus_if.strike = 4'h0;
    setDigits(4'd9, 4'd9, 4'd9);
    idleCycles(3);
    reset = 1'b0;
    compare_on = 1'b1;
    checkOutput("reset game_state", int'(bus_if.game_state), 32'h00);
    checkOutput("reset solved_mask", int'(bus_if.solved_mask), 32'h0);
    checkOutput("reset module_enable", int'(bus_if.module_enable), 32'h0);
    checkOutput("reset strike_count", int'(bus_if.strike_count), 0);
    checkOutput("reset state_change", int'(bus_if.state_change), 0);

    applyStimulus(1'b0, 4'b0001, 4'b0010);
    checkOutput("idle ignores solved", int'(bus_if.solved_mask), 32'h0);
    checkOutput("idle ignores strike", int'(bus_if.strike_count), 0);

    // Game 1: zero digits through ARMING and the first two RUNNING cycles, then solve all four.
    setDigits(4'd0, 4'd0, 4'd0);
    applyStimulus(1'b1, 4'h0, 4'h0);
    checkOutput("arming entered", int'(bus_if.game_state), 32'h01);
    checkOutput("arming change pulse", int'(bus_if.state_change), 1);
    idleCycles(1);
    checkOutput("change pulse one cycle", int'(bus_if.state_change), 0);
    applyStimulus(1'b1, 4'h0, 4'h0);
    idleCycles(ARM_CYCLES - 3);
    checkOutput("still arming at edge 16", int'(bus_if.game_state), 32'h01);
    idleCycles(1);
    checkOutput("running at edge 17", int'(bus_if.game_state), 32'h10);
    checkOutput("all enabled", int'(bus_if.module_enable), 32'hF);
    checkOutput("running change pulse", int'(bus_if.state_change), 1);
    idleCycles(2);
    checkOutput("expiry holdoff", int'(bus_if.game_state), 32'h10);
    setDigits(4'd9, 4'd9, 4'd9);
    applyStimulus(1'b1, 4'h0, 4'h0);
    checkOutput("start ignored running", int'(bus_if.game_state), 32'h10);
    applyStimulus(1'b0, 4'b0001, 4'h0);
    checkOutput("mask after solve0", int'(bus_if.solved_mask), 32'h1);
    checkOutput("enable after solve0", int'(bus_if.module_enable), 32'hE);
    applyStimulus(1'b0, 4'b0010, 4'h0);
    applyStimulus(1'b0, 4'b0100, 4'h0);
    checkOutput("mask after solve2", int'(bus_if.solved_mask), 32'h7);
    applyStimulus(1'b0, 4'b1000, 4'h0);
    checkOutput("defused", int'(bus_if.game_state), 32'h20);
    checkOutput("defused enables", int'(bus_if.module_enable), 32'h0);
    idleCycles(2);
    applyStimulus(1'b0, 4'h0, 4'b0100);
    checkOutput("defused frozen", int'(bus_if.game_state), 32'h20);
    checkOutput("defused strikes frozen", int'(bus_if.strike_count), 0);
    applyStimulus(1'b1, 4'h0, 4'h0);
    checkOutput("restart to idle", int'(bus_if.game_state), 32'h00);

    // Game 2: three strikes on module 2.
    startGame();
    checkOutput("mask cleared", int'(bus_if.solved_mask), 32'h0);
    applyStimulus(1'b0, 4'h0, 4'b0100);
    checkOutput("strike 1", int'(bus_if.strike_count), 1);
    applyStimulus(1'b0, 4'h0, 4'b0100);
    checkOutput("strike 2", int'(bus_if.strike_count), 2);
    checkOutput("alive at 2", int'(bus_if.game_state), 32'h10);
    applyStimulus(1'b0, 4'h0, 4'b0100);
    checkOutput("strike 3", int'(bus_if.strike_count), 3);
    checkOutput("exploded by strikes", int'(bus_if.game_state), 32'h30);
    applyStimulus(1'b1, 4'h0, 4'h0);

    // Game 3: strikes on solved modules dropped, then a double strike saturates.
    startGame();
    applyStimulus(1'b0, 4'b1000, 4'h0);
    applyStimulus(1'b0, 4'h0, 4'b1000);
    checkOutput("solved strike dropped", int'(bus_if.strike_count), 0);
    applyStimulus(1'b0, 4'b0100, 4'b0100);
    checkOutput("same-cycle solve wins", int'(bus_if.strike_count), 0);
    checkOutput("same-cycle mask", int'(bus_if.solved_mask), 32'hC);
    applyStimulus(1'b0, 4'h0, 4'b0001);
    applyStimulus(1'b0, 4'h0, 4'b0001);
    applyStimulus(1'b0, 4'h0, 4'b0011);
    checkOutput("saturated count", int'(bus_if.strike_count), 3);
    checkOutput("exploded by double strike", int'(bus_if.game_state), 32'h30);
    applyStimulus(1'b1, 4'h0, 4'h0);

    // Game 4: expiry with three modules solved.
    startGame();
    applyStimulus(1'b0, 4'b0001, 4'h0);
    applyStimulus(1'b0, 4'b0010, 4'h0);
    applyStimulus(1'b0, 4'b0100, 4'h0);
    setDigits(4'd0, 4'd0, 4'd0);
    idleCycles(1);
    checkOutput("exploded by timer", int'(bus_if.game_state), 32'h30);
    setDigits(4'd9, 4'd9, 4'd9);
    applyStimulus(1'b1, 4'h0, 4'h0);

    // Game 5: final solve on the zero cycle still defuses.
    startGame();
    applyStimulus(1'b0, 4'b0001, 4'h0);
    applyStimulus(1'b0, 4'b0010, 4'h0);
    applyStimulus(1'b0, 4'b0100, 4'h0);
    setDigits(4'd0, 4'd0, 4'd0);
    applyStimulus(1'b0, 4'b1000, 4'h0);
    checkOutput("solve beats expiry", int'(bus_if.game_state), 32'h20);
    setDigits(4'd9, 4'd9, 4'd9);
    applyStimulus(1'b1, 4'h0, 4'h0);

    // Game 6: reset in the middle of RUNNING.
    startGame();
    applyStimulus(1'b0, 4'b0001, 4'b0010);
    reset = 1'b1;
    idleCycles(1);
    reset = 1'b0;
    checkOutput("midgame reset state", int'(bus_if.game_state), 32'h00);
    checkOutput("midgame reset mask", int'(bus_if.solved_mask), 32'h0);
    checkOutput("midgame reset enable", int'(bus_if.module_enable), 32'h0);
    checkOutput("midgame reset strikes", int'(bus_if.strike_count), 0);
    checkOutput("midgame reset change", int'(bus_if.state_change), 1);
    idleCycles(1);
    checkOutput("post reset change", int'(bus_if.state_change), 0);

    compare_on = 1'b0;
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
